// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM encoding, default widths and sample types for the merge sorter
package sort_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [2:0] {IDLE, LOAD, PASS, DRAIN, FLUSH} fsm_t;

    typedef logic [ADDR_WIDTH_DEF-1:0] tag_t;

    typedef struct packed {
        logic signed [DATA_WIDTH_DEF-1:0] data;
        tag_t                             idx;
    } sample_t;

endpackage

// File: rtl/sort_tdp_ram.sv
// rtl/sort_tdp_ram.sv - true dual-port RAM with a two-stage registered read path on each port
module sort_tdp_ram #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd1_a_q, rd1_b_q, rd2_a_q, rd2_b_q;

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
        rd1_a_q <= mem[addr_a];
        rd1_b_q <= mem[addr_b];
        rd2_a_q <= rd1_a_q;
        rd2_b_q <= rd1_b_q;
    end

    assign rdata_a = rd2_a_q;
    assign rdata_b = rd2_b_q;

endmodule

// File: rtl/merge_sorter_p.sv
// rtl/merge_sorter_p.sv - frame merge sorter: loads a frame, runs bottom-up ping/pong merge passes,
// and streams the final merge straight to the output with original arrival indices.
module merge_sorter_p
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int IDX_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  descending,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  overflow,
    output logic                  busy
);

    localparam int W = DATA_WIDTH + ADDR_WIDTH;
    typedef logic [ADDR_WIDTH:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);
    localparam cnt_t CAP = cnt_t'(1) << ADDR_WIDTH;

    fsm_t state_q, state_d;
    logic in_ready_q, in_ready_d, desc_q, desc_d, src_q, src_d, overflow_q, overflow_d;
    cnt_t cnt_q, cnt_d, s_q, s_d, lo_q, lo_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic [1:0] ph_q, ph_d;
    logic out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;

    logic [W-1:0] a_rd_a, a_rd_b, b_rd_a, b_rd_b, rd_l, rd_r, pick, load_word;
    logic signed [DATA_WIDTH-1:0] key_l, key_r;
    cnt_t i_end, j_end, s2, lo_n, n_sort;
    logic take_l, load_we, pass_we, start_sort, block_done;
    logic [ADDR_WIDTH-1:0] load_addr, load_tag;

    // Run boundaries are clipped at the frame length so a short trailing run is simply copied.
    assign rd_l       = src_q ? b_rd_a : a_rd_a;
    assign rd_r       = src_q ? b_rd_b : a_rd_b;
    assign key_l      = rd_l[W-1 -: DATA_WIDTH];
    assign key_r      = rd_r[W-1 -: DATA_WIDTH];
    assign s2         = s_q << 1;
    assign lo_n       = lo_q + s2;
    assign i_end      = (lo_q + s_q < cnt_q) ? lo_q + s_q : cnt_q;
    assign j_end      = (lo_n < cnt_q) ? lo_n : cnt_q;
    assign take_l     = (i_q < i_end) &&
                        (!(j_q < j_end) || (desc_q ? (key_l >= key_r) : (key_l <= key_r)));
    assign pick       = take_l ? rd_l : rd_r;
    assign block_done = (k_q + ONE == j_end);
    assign load_tag   = (IDX_EN != 0) ? load_addr : {ADDR_WIDTH{1'b0}};
    assign load_word  = {in_data, load_tag};

    sort_tdp_ram #(.WIDTH(W), .DEPTH(1 << ADDR_WIDTH), .AW(ADDR_WIDTH)) u_ram_a (
        .clk     (clk),
        .we_a    (load_we | (pass_we & src_q)),
        .addr_a  (load_we ? load_addr : (src_q ? k_q[ADDR_WIDTH-1:0] : i_q[ADDR_WIDTH-1:0])),
        .wdata_a (load_we ? load_word : pick),
        .rdata_a (a_rd_a),
        .we_b    (1'b0),
        .addr_b  (j_q[ADDR_WIDTH-1:0]),
        .wdata_b ({W{1'b0}}),
        .rdata_b (a_rd_b)
    );

    sort_tdp_ram #(.WIDTH(W), .DEPTH(1 << ADDR_WIDTH), .AW(ADDR_WIDTH)) u_ram_b (
        .clk     (clk),
        .we_a    (pass_we & ~src_q),
        .addr_a  (src_q ? i_q[ADDR_WIDTH-1:0] : k_q[ADDR_WIDTH-1:0]),
        .wdata_a (pick),
        .rdata_a (b_rd_a),
        .we_b    (1'b0),
        .addr_b  (j_q[ADDR_WIDTH-1:0]),
        .wdata_b ({W{1'b0}}),
        .rdata_b (b_rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;       in_ready_q <= 1'b0;   desc_q <= 1'b0;      src_q <= 1'b0;
            overflow_q <= 1'b0;    cnt_q <= '0;          s_q <= '0;           lo_q <= '0;
            i_q <= '0;             j_q <= '0;            k_q <= '0;           ph_q <= '0;
            out_valid_q <= 1'b0;   out_first_q <= 1'b0;  out_last_q <= 1'b0;
            out_data_q <= '0;      out_idx_q <= '0;
        end else begin
            state_q <= state_d;    in_ready_q <= in_ready_d; desc_q <= desc_d; src_q <= src_d;
            overflow_q <= overflow_d; cnt_q <= cnt_d;    s_q <= s_d;          lo_q <= lo_d;
            i_q <= i_d;            j_q <= j_d;           k_q <= k_d;          ph_q <= ph_d;
            out_valid_q <= out_valid_d; out_first_q <= out_first_d; out_last_q <= out_last_d;
            out_data_q <= out_data_d;   out_idx_q <= out_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;   desc_d = desc_q;   src_d = src_q;   cnt_d = cnt_q;
        s_d = s_q;           lo_d = lo_q;       i_d = i_q;       j_d = j_q;
        k_d = k_q;           ph_d = ph_q;       overflow_d = 1'b0;
        out_valid_d = out_valid_q; out_first_d = out_first_q; out_last_d = out_last_q;
        out_data_d = out_data_q;   out_idx_d = out_idx_q;
        load_we = 1'b0;  load_addr = '0;  pass_we = 1'b0;  start_sort = 1'b0;  n_sort = cnt_q;
        case (state_q)
            IDLE, LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (in_first) begin
                        load_we = 1'b1;
                        desc_d  = descending;
                        cnt_d   = ONE;
                        state_d = LOAD;
                        if (in_last) begin
                            start_sort = 1'b1;
                            n_sort     = ONE;
                        end
                    end else if (state_q == LOAD) begin
                        if (cnt_q == CAP) begin
                            overflow_d = 1'b1;
                            if (in_last) start_sort = 1'b1;
                            else         state_d    = FLUSH;
                        end else begin
                            load_we   = 1'b1;
                            load_addr = cnt_q[ADDR_WIDTH-1:0];
                            cnt_d     = cnt_q + ONE;
                            if (in_last) begin
                                start_sort = 1'b1;
                                n_sort     = cnt_q + ONE;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (in_valid && in_ready_q && in_last) start_sort = 1'b1;
            end
            PASS: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    pass_we = 1'b1;
                    ph_d    = '0;
                    k_d     = k_q + ONE;
                    if (take_l) i_d = i_q + ONE;
                    else        j_d = j_q + ONE;
                    if (block_done) begin
                        if (lo_n >= cnt_q) begin
                            s_d     = s2;
                            src_d   = ~src_q;
                            lo_d    = '0;
                            i_d     = '0;
                            j_d     = s2;
                            k_d     = '0;
                            state_d = ((s2 << 1) >= cnt_q) ? DRAIN : PASS;
                        end else begin
                            lo_d = lo_n;
                            i_d  = lo_n;
                            j_d  = lo_n + s_q;
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) state_d = IDLE;
                end
                // The next read is already in flight while the current beat is held for the sink.
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else if ((!out_valid_q || out_ready) && (k_q != cnt_q)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pick[W-1 -: DATA_WIDTH];
                    out_idx_d   = pick[ADDR_WIDTH-1:0];
                    out_first_d = (k_q == '0);
                    out_last_d  = (k_q + ONE == cnt_q);
                    ph_d        = '0;
                    k_d         = k_q + ONE;
                    if (take_l) i_d = i_q + ONE;
                    else        j_d = j_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_sort) begin
            cnt_d   = n_sort;
            s_d     = ONE;
            lo_d    = '0;
            i_d     = '0;
            j_d     = ONE;
            k_d     = '0;
            ph_d    = '0;
            src_d   = 1'b0;
            state_d = (n_sort <= cnt_t'(2)) ? DRAIN : PASS;
        end
        in_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == FLUSH);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_merge_sorter_p.sv
// tb/tb_merge_sorter_p.sv - directed self-checking bench for merge_sorter_p (ADDR_WIDTH=3)
module tb_merge_sorter_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        descending = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_first;
    logic        out_last;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        overflow;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    int got_d [16];
    int got_i [16];
    bit got_f [16];
    bit got_l [16];
    int got_n, got_extra, hold_bad;
    bit busy_after, rdy_after;
    int ovf_cnt, ovf_beat;

    merge_sorter_p #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .IDX_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .descending (descending),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_last    (in_last),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic send_frame(input int n, input int vals[16], input bit desc);
        int k = 0;
        int cyc = 0;
        int acc = 0;
        ovf_cnt = 0;
        ovf_beat = -1;
        while (k < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (overflow) begin ovf_cnt++; ovf_beat = acc; end
            in_valid   = 1'b1;
            in_data    = 16'(vals[k]);
            in_first   = (k == 0);
            in_last    = (k == n - 1);
            descending = desc;
            if (in_ready) begin k++; acc++; end
        end
        @(negedge clk);
        if (overflow) begin ovf_cnt++; ovf_beat = acc; end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        if (k < n) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", k, n);
        end
    endtask

    task automatic collect(input int n, input int pct);
        int cyc = 0;
        bit hold = 0;
        logic [15:0] hd;
        logic [2:0] hi;
        logic hf, hl;
        got_n = 0; got_extra = 0; hold_bad = 0;
        while (got_n < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold && (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi ||
                         out_first !== hf || out_last !== hl)) hold_bad++;
            out_ready = ($urandom_range(99) < pct);
            hold = 0;
            if (out_valid && out_ready) begin
                got_d[got_n] = int'($signed(out_data));
                got_i[got_n] = int'(out_idx);
                got_f[got_n] = out_first;
                got_l[got_n] = out_last;
                got_n++;
            end else if (out_valid) begin
                hold = 1; hd = out_data; hi = out_idx; hf = out_first; hl = out_last;
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c == 0) begin busy_after = busy; rdy_after = in_ready; end
            if (out_valid) got_extra++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_chk++;
        if ({in_ready, out_valid, out_first, out_last, overflow, busy} !== 6'b0 ||
            out_data !== 16'd0 || out_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b v=%b f=%b l=%b ovf=%b busy=%b d=%0d i=%0d, required all 0",
                     in_ready, out_valid, out_first, out_last, overflow, busy, out_data, out_idx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL in_ready_before_edge: got %b, required 0", in_ready);
        end
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL in_ready_rise: rdy=%b busy=%b, required rdy=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_ascending();
        int v[16];
        int ed[8];
        int ei[8];
        v  = '{5, 3, 8, 1, 8, 0, -2, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        ed = '{-2, 0, 1, 3, 5, 7, 8, 8};
        ei = '{6, 5, 3, 1, 0, 7, 2, 4};
        send_frame(8, v, 1'b0);
        n_chk++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL asc_after_last: rdy=%b busy=%b, required rdy=0 busy=1", in_ready, busy);
        end
        collect(8, 100);
        n_chk++;
        if (got_n != 8 || got_extra != 0) begin
            n_fail++; $display("FAIL asc_count: got %0d beats (+%0d extra), required 8", got_n, got_extra);
        end
        for (int b = 0; b < got_n; b++) begin
            n_chk++;
            if (got_d[b] != ed[b] || got_i[b] != ei[b] || got_f[b] != (b == 0) || got_l[b] != (b == 7)) begin
                n_fail++;
                $display("FAIL asc_beat%0d: d=%0d i=%0d f=%b l=%b, required d=%0d i=%0d f=%b l=%b",
                         b, got_d[b], got_i[b], got_f[b], got_l[b], ed[b], ei[b], b == 0, b == 7);
            end
        end
        n_chk++;
        if (busy_after !== 1'b0 || rdy_after !== 1'b1) begin
            n_fail++; $display("FAIL asc_idle: busy=%b rdy=%b, required busy=0 rdy=1", busy_after, rdy_after);
        end
    endtask

    task automatic test_descending();
        int v[16];
        int ed[5];
        int ei[5];
        v  = '{2, 2, 9, -1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ed = '{9, 2, 2, 2, -1};
        ei = '{2, 0, 1, 4, 3};
        send_frame(5, v, 1'b1);
        collect(5, 100);
        n_chk++;
        if (got_n != 5 || got_extra != 0) begin
            n_fail++; $display("FAIL desc_count: got %0d beats (+%0d extra), required 5", got_n, got_extra);
        end
        for (int b = 0; b < got_n; b++) begin
            n_chk++;
            if (got_d[b] != ed[b] || got_i[b] != ei[b] || got_f[b] != (b == 0) || got_l[b] != (b == 4)) begin
                n_fail++;
                $display("FAIL desc_beat%0d: d=%0d i=%0d f=%b l=%b, required d=%0d i=%0d",
                         b, got_d[b], got_i[b], got_f[b], got_l[b], ed[b], ei[b]);
            end
        end
    endtask

    task automatic test_single();
        int v[16];
        v = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1, v, 1'b0);
        collect(1, 100);
        n_chk++;
        if (got_n != 1 || got_extra != 0 || got_d[0] != 42 || got_i[0] != 0 || !got_f[0] || !got_l[0]) begin
            n_fail++;
            $display("FAIL single_beat: n=%0d extra=%0d d=%0d i=%0d f=%b l=%b, required n=1 d=42 i=0 f=1 l=1",
                     got_n, got_extra, got_d[0], got_i[0], got_f[0], got_l[0]);
        end
        n_chk++;
        if (busy_after !== 1'b0 || rdy_after !== 1'b1) begin
            n_fail++; $display("FAIL single_idle: busy=%b rdy=%b, required busy=0 rdy=1", busy_after, rdy_after);
        end
    endtask

    task automatic test_overflow();
        int v[16];
        v = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
        send_frame(11, v, 1'b0);
        n_chk++;
        if (ovf_cnt != 1 || ovf_beat != 9) begin
            n_fail++; $display("FAIL ovf_pulse: pulses=%0d on beat %0d, required 1 pulse on beat 9", ovf_cnt, ovf_beat);
        end
        collect(8, 100);
        n_chk++;
        if (got_n != 8 || got_extra != 0) begin
            n_fail++; $display("FAIL ovf_count: got %0d beats (+%0d extra), required 8", got_n, got_extra);
        end
        for (int b = 0; b < got_n; b++) begin
            n_chk++;
            if (got_d[b] != b + 3 || got_i[b] != 7 - b) begin
                n_fail++;
                $display("FAIL ovf_beat%0d: d=%0d i=%0d, required d=%0d i=%0d", b, got_d[b], got_i[b], b + 3, 7 - b);
            end
        end
    endtask

    task automatic test_random_ready();
        int v[16];
        int ed[8];
        int ei[8];
        v  = '{100, -5, 33, -5, 0, 7, -32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0};
        ed = '{-32768, -5, -5, 0, 7, 33, 100, 32767};
        ei = '{6, 1, 3, 4, 5, 2, 0, 7};
        send_frame(8, v, 1'b0);
        collect(8, 30);
        n_chk++;
        if (got_n != 8 || got_extra != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d beats (+%0d extra), required 8", got_n, got_extra);
        end
        n_chk++;
        if (hold_bad != 0) begin
            n_fail++; $display("FAIL bp_hold: %0d stalled beats changed, required 0", hold_bad);
        end
        for (int b = 0; b < got_n; b++) begin
            n_chk++;
            if (got_d[b] != ed[b] || got_i[b] != ei[b] || got_f[b] != (b == 0) || got_l[b] != (b == 7)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: d=%0d i=%0d f=%b l=%b, required d=%0d i=%0d",
                         b, got_d[b], got_i[b], got_f[b], got_l[b], ed[b], ei[b]);
            end
        end
    endtask

    task automatic test_reset_drain();
        int v[16];
        int cyc = 0;
        v = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(4, v, 1'b0);
        while (!out_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 16'd1) begin
            n_fail++; $display("FAIL rd_pre_drain: v=%b d=%0d, required v=1 d=1", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, out_valid, out_first, out_last, overflow, busy} !== 6'b0 ||
            out_data !== 16'd0 || out_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL rd_async_clear: rdy=%b v=%b f=%b l=%b ovf=%b busy=%b d=%0d i=%0d, required all 0",
                     in_ready, out_valid, out_first, out_last, overflow, busy, out_data, out_idx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v = '{3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(3, v, 1'b0);
        collect(3, 100);
        n_chk++;
        if (got_n != 3 || got_extra != 0 ||
            got_d[0] != 1 || got_d[1] != 2 || got_d[2] != 3 ||
            got_i[0] != 1 || got_i[1] != 2 || got_i[2] != 0) begin
            n_fail++;
            $display("FAIL rd_new_frame: n=%0d extra=%0d d=%0d,%0d,%0d i=%0d,%0d,%0d, required n=3 d=1,2,3 i=1,2,0",
                     got_n, got_extra, got_d[0], got_d[1], got_d[2], got_i[0], got_i[1], got_i[2]);
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_single();
        test_overflow();
        test_random_ready();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
